instr_fetch: RTL

//  IF stage of the 5-stage MIPS pipeline. Owns the PC, issues word fetches to instruction memory

---
 rtl/instr_fetch_pkg.sv | 29 ++
 rtl/instr_fetch.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch (IF) stage.
//   ADDR_WIDTH / INSTR_WIDTH : datapath widths
//   INSTR_NOP                : SLL $0,$0,0, injected into IF/ID as a bubble
//   if_state_e               : fetch FSM encoding (REQ / HELD / DRAIN)
//   hold_t                   : one-entry hold buffer contents (instruction + its PC+4)
package instr_fetch_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = '0;

  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,  // request outstanding at pc
    IF_HELD  = 2'd1,  // fetched word parked in the hold buffer during a stall
    IF_DRAIN = 2'd2   // waiting out a pre-redirect request whose data is discarded
  } if_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
  } hold_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// IF stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches words from instruction memory over a req/rdy handshake and
// drives the IF/ID register (instr, PC+4, valid) consumed by instr_decode.
// Stalls are absorbed by a one-entry hold buffer; redirects squash IF/ID to a NOP
// bubble and, if a request is still in flight, drain it before refetching.
// Ports:
//   clk_87, rst_87                   clock, synchronous active-high reset
//   stall_87                         hold PC and IF/ID this cycle
//   redirect_87, redirect_addr_87    refetch from redirect target (low 2 bits ignored)
//   imem_req_87, imem_addr_87        fetch request / address to instruction memory
//   imem_rdy_87, imem_data_87        fetch completion / instruction word
//   instr_87, pc_out_87, valid_87    IF/ID register outputs
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic                   clk_87,
  input  logic                   rst_87,
  input  logic                   stall_87,
  input  logic                   redirect_87,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_87,
  output logic                   imem_req_87,
  output logic [ADDR_WIDTH-1:0]  imem_addr_87,
  input  logic                   imem_rdy_87,
  input  logic [INSTR_WIDTH-1:0] imem_data_87,
  output logic [INSTR_WIDTH-1:0] instr_87,
  output logic [ADDR_WIDTH-1:0]  pc_out_87,
  output logic                   valid_87
);

  if_state_e              state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  drain_addr_q;
  hold_t                  hold_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_out_q;
  logic                   valid_q;

  logic [ADDR_WIDTH-1:0]  pc_plus4;

  // Wraps modulo 2^ADDR_WIDTH by construction of the width.
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  // Request is gated by reset so an abandoned fetch is not re-presented during reset.
  assign imem_req_87  = ((state_q == IF_REQ) || (state_q == IF_DRAIN)) && !rst_87;
  assign imem_addr_87 = (state_q == IF_DRAIN) ? drain_addr_q : pc_q;

  assign instr_87  = instr_q;
  assign pc_out_87 = pc_out_q;
  assign valid_87  = valid_q;

  // NOTE: all state here is sequential and uses non-blocking assignment so every
  // register samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      state_q      <= IF_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      hold_q       <= '0;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else if (redirect_87) begin
      // Redirect overrides stall in every state; IF/ID becomes a bubble, pc_out kept.
      pc_q    <= word_align(redirect_addr_87);
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      unique case (state_q)
        IF_REQ: begin
          if (imem_rdy_87) begin
            state_q <= IF_REQ;  // transfer completes now; its data is simply dropped
          end else begin
            state_q      <= IF_DRAIN;
            drain_addr_q <= pc_q;  // address must stay put until memory answers
          end
        end
        IF_HELD:  state_q <= IF_REQ;  // hold buffer contents abandoned
        // A drained transfer that completes this very cycle is finished; otherwise
        // keep draining the original address and only retarget pc.
        IF_DRAIN: state_q <= imem_rdy_87 ? IF_REQ : IF_DRAIN;
        default:  state_q <= IF_REQ;
      endcase
    end else begin
      unique case (state_q)
        IF_REQ: begin
          if (imem_rdy_87) begin
            pc_q <= pc_plus4;
            if (stall_87) begin
              hold_q  <= '{instr: imem_data_87, pc_plus4: pc_plus4};
              state_q <= IF_HELD;
            end else begin
              instr_q  <= imem_data_87;
              pc_out_q <= pc_plus4;
              valid_q  <= 1'b1;
            end
          end else if (!stall_87) begin
            // Memory still busy: push a bubble down the pipe, keep pc_out.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        IF_HELD: begin
          if (!stall_87) begin
            instr_q  <= hold_q.instr;
            pc_out_q <= hold_q.pc_plus4;
            valid_q  <= 1'b1;
            state_q  <= IF_REQ;
          end
        end
        IF_DRAIN: begin
          // Stale data is discarded; IF/ID already holds the redirect bubble.
          if (imem_rdy_87) state_q <= IF_REQ;
        end
        default: state_q <= IF_REQ;
      endcase
    end
  end

endmodule
